// File: rtl/ibex_multdiv_arbiter_if.sv
// Signal bundle between the multdiv arbiter, its two requesters and the shared mult/div unit.
// master: the arbiter side; slave: requesters plus unit.
interface ibex_multdiv_arbiter_if;
  logic [1:0]  req_valid_i;
  logic [1:0]  req_ready_o;
  logic [3:0]  req_operator_i;
  logic [3:0]  req_signed_mode_i;
  logic [63:0] req_op_a_i;
  logic [63:0] req_op_b_i;

  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic        rsp_id_o;
  logic [31:0] rsp_result_o;

  logic        mult_en_o;
  logic        div_en_o;
  logic [1:0]  operator_o;
  logic [1:0]  signed_mode_o;
  logic [31:0] op_a_o;
  logic [31:0] op_b_o;
  logic        md_valid_i;
  logic [31:0] md_result_i;

  logic        busy_o;
  logic        wdog_err_o;

  modport master (
    input  req_valid_i, req_operator_i, req_signed_mode_i, req_op_a_i, req_op_b_i,
    input  rsp_ready_i, md_valid_i, md_result_i,
    output req_ready_o, rsp_valid_o, rsp_id_o, rsp_result_o,
    output mult_en_o, div_en_o, operator_o, signed_mode_o, op_a_o, op_b_o,
    output busy_o, wdog_err_o
  );

  modport slave (
    output req_valid_i, req_operator_i, req_signed_mode_i, req_op_a_i, req_op_b_i,
    output rsp_ready_i, md_valid_i, md_result_i,
    input  req_ready_o, rsp_valid_o, rsp_id_o, rsp_result_o,
    input  mult_en_o, div_en_o, operator_o, signed_mode_o, op_a_o, op_b_o,
    input  busy_o, wdog_err_o
  );
endinterface

// File: rtl/ibex_multdiv_arbiter.sv
// Round-robin arbiter sharing one multi-cycle mult/div unit between two requesters,
// with latched operands, a tagged response channel and a sticky busy watchdog.
module ibex_multdiv_arbiter #(
  parameter int unsigned WDOG_CYCLES = 63
) (
  input logic                   clk,
  input logic                   rst_i,
  ibex_multdiv_arbiter_if.master bus
);

  typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

  state_e      r_state, w_state_next;
  logic        r_last;  // requester granted most recently
  logic        r_id;
  logic [1:0]  r_op;
  logic [1:0]  r_sm;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [31:0] r_result;
  logic [15:0] r_cnt;
  logic        r_err;

  logic        w_accept;
  logic        w_grant_id;
  logic        w_busy_en;
  logic [15:0] w_cnt_inc;
  logic        w_wdog_hit;

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_grant_id   = 1'b0;
    case (r_state)
      StIdle: begin
        if (bus.req_valid_i != 2'b00) begin
          w_accept     = 1'b1;
          w_state_next = StBusy;
          case (bus.req_valid_i)
            2'b01:   w_grant_id = 1'b0;
            2'b10:   w_grant_id = 1'b1;
            default: w_grant_id = ~r_last;
          endcase
        end
      end
      StBusy: begin
        if (bus.md_valid_i) w_state_next = StResp;
      end
      StResp: begin
        if (bus.rsp_ready_i) w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  assign w_cnt_inc  = (r_cnt == 16'hFFFF) ? r_cnt : r_cnt + 16'd1;
  assign w_wdog_hit = 32'(w_cnt_inc) >= WDOG_CYCLES;

  // Combinational handshakes are masked while reset is asserted so outputs read 0 at once.
  assign w_busy_en       = (r_state == StBusy) && !rst_i;
  assign bus.req_ready_o = (w_accept && !rst_i) ? (w_grant_id ? 2'b10 : 2'b01) : 2'b00;
  assign bus.mult_en_o   = w_busy_en && !r_op[1];
  assign bus.div_en_o    = w_busy_en && r_op[1];
  assign bus.operator_o    = r_op;
  assign bus.signed_mode_o = r_sm;
  assign bus.op_a_o        = r_a;
  assign bus.op_b_o        = r_b;
  assign bus.rsp_valid_o   = (r_state == StResp);
  assign bus.rsp_id_o      = r_id;
  assign bus.rsp_result_o  = r_result;
  assign bus.busy_o        = (r_state != StIdle);
  assign bus.wdog_err_o    = r_err;

  always_ff @(posedge clk) begin
    if (rst_i) begin
      r_state  <= StIdle;
      r_last   <= 1'b1;
      r_id     <= 1'b0;
      r_op     <= 2'b00;
      r_sm     <= 2'b00;
      r_a      <= 32'd0;
      r_b      <= 32'd0;
      r_result <= 32'd0;
      r_cnt    <= 16'd0;
      r_err    <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_last <= w_grant_id;
        r_id   <= w_grant_id;
        r_op   <= w_grant_id ? bus.req_operator_i[3:2]    : bus.req_operator_i[1:0];
        r_sm   <= w_grant_id ? bus.req_signed_mode_i[3:2] : bus.req_signed_mode_i[1:0];
        r_a    <= w_grant_id ? bus.req_op_a_i[63:32]      : bus.req_op_a_i[31:0];
        r_b    <= w_grant_id ? bus.req_op_b_i[63:32]      : bus.req_op_b_i[31:0];
        r_cnt  <= 16'd0;
      end
      if (r_state == StBusy) begin
        if (bus.md_valid_i) begin
          r_result <= bus.md_result_i;
        end else begin
          r_cnt <= w_cnt_inc;
          if (w_wdog_hit) r_err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ibex_multdiv_arbiter.sv
// Bench for ibex_multdiv_arbiter: transaction-level model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_ibex_multdiv_arbiter;
  localparam int unsigned WDOG = 8;

  logic clk = 1'b0;
  logic rst_i;
  ibex_multdiv_arbiter_if bus ();

  ibex_multdiv_arbiter #(.WDOG_CYCLES(WDOG)) dut (
    .clk   (clk),
    .rst_i (rst_i),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Transaction-level model state
  bit          m_inflight, m_resp, m_id, m_err;
  int          m_last, m_stall, m_grant;
  logic [1:0]  m_op, m_sm;
  logic [31:0] m_a, m_b, m_res;
  bit          pend [2];

  function automatic logic [31:0] unit_calc(input logic [1:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    logic [63:0] p;
    p = 64'(a) * 64'(b);
    case (op)
      2'd0:    return p[31:0];
      2'd1:    return p[63:32];
      2'd2:    return (b == 0) ? 32'hFFFF_FFFF : a / b;
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_req(input int r, input logic [1:0] op, input logic [1:0] sm,
                         input logic [31:0] a, input logic [31:0] b);
    bus.req_operator_i[r*2 +: 2]    = op;
    bus.req_signed_mode_i[r*2 +: 2] = sm;
    bus.req_op_a_i[r*32 +: 32]      = a;
    bus.req_op_b_i[r*32 +: 32]      = b;
  endtask

  task automatic model_reset();
    m_inflight = 0; m_resp = 0; m_id = 0; m_err = 0;
    m_last = 1; m_stall = 0; m_grant = -1;
    m_op = '0; m_sm = '0; m_a = '0; m_b = '0; m_res = '0;
  endtask

  // Wait to the falling edge and compare every output against the model.
  task automatic settle();
    logic [1:0] e_ready;
    bit         en;
    @(negedge clk);
    m_grant = -1;
    if (!rst_i && !m_inflight && !m_resp) begin
      case (bus.req_valid_i)
        2'b01:   m_grant = 0;
        2'b10:   m_grant = 1;
        2'b11:   m_grant = 1 - m_last;
        default: m_grant = -1;
      endcase
    end
    e_ready = (m_grant < 0) ? 2'b00 : ((m_grant == 0) ? 2'b01 : 2'b10);
    en = m_inflight && !rst_i;
    chk("req_ready", 32'(bus.req_ready_o), 32'(e_ready));
    chk("busy", 32'(bus.busy_o), 32'(m_inflight || m_resp));
    chk("mult_en", 32'(bus.mult_en_o), 32'(en && (m_op < 2)));
    chk("div_en", 32'(bus.div_en_o), 32'(en && (m_op >= 2)));
    chk("operator", 32'(bus.operator_o), 32'(m_op));
    chk("signed_mode", 32'(bus.signed_mode_o), 32'(m_sm));
    chk("op_a", bus.op_a_o, m_a);
    chk("op_b", bus.op_b_o, m_b);
    chk("rsp_valid", 32'(bus.rsp_valid_o), 32'(m_resp));
    chk("rsp_id", 32'(bus.rsp_id_o), 32'(m_id));
    chk("rsp_result", bus.rsp_result_o, m_res);
    chk("wdog_err", 32'(bus.wdog_err_o), 32'(m_err));
  endtask

  // Apply the clock edge to the model, then move to just after the DUT edge.
  task automatic advance();
    if (rst_i) begin
      model_reset();
    end else if (m_grant >= 0) begin
      m_id       = m_grant[0];
      m_op       = bus.req_operator_i[m_grant*2 +: 2];
      m_sm       = bus.req_signed_mode_i[m_grant*2 +: 2];
      m_a        = bus.req_op_a_i[m_grant*32 +: 32];
      m_b        = bus.req_op_b_i[m_grant*32 +: 32];
      m_last     = m_grant;
      m_inflight = 1;
      m_stall    = 0;
    end else if (m_inflight) begin
      if (bus.md_valid_i) begin
        m_res      = bus.md_result_i;
        m_inflight = 0;
        m_resp     = 1;
      end else begin
        if (m_stall < 65535) m_stall++;
        if (m_stall >= int'(WDOG)) m_err = 1;
      end
    end else if (m_resp && bus.rsp_ready_i) begin
      m_resp = 0;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    model_reset();
    rst_i = 1'b1;
    bus.req_valid_i = '0; bus.req_operator_i = '0; bus.req_signed_mode_i = '0;
    bus.req_op_a_i = '0; bus.req_op_b_i = '0;
    bus.rsp_ready_i = 1'b0; bus.md_valid_i = 1'b0; bus.md_result_i = '0;
    pend[0] = 0; pend[1] = 0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      settle();
      advance();
    end
    rst_i = 1'b0;

    // Tie right after reset: req0 MULL 7*6 wins, req1 DIV 100/7 waits.
    set_req(0, 2'd0, 2'd0, 32'd7, 32'd6);
    set_req(1, 2'd2, 2'd0, 32'd100, 32'd7);
    bus.req_valid_i = 2'b11;
    settle();
    chk("lit_first_tie_ready", 32'(bus.req_ready_o), 32'h1);
    chk("lit_idle_busy", 32'(bus.busy_o), 32'h0);
    advance();
    bus.req_valid_i = 2'b10;
    settle();
    chk("lit_mull_en_c1", 32'(bus.mult_en_o), 32'h1);
    advance();
    bus.md_valid_i = 1'b1;
    bus.md_result_i = unit_calc(2'd0, 32'd7, 32'd6);
    settle();
    chk("lit_mull_en_valid_cycle", 32'(bus.mult_en_o), 32'h1);
    advance();
    bus.md_valid_i = 1'b0;
    bus.rsp_ready_i = 1'b1;
    settle();
    chk("lit_mull_rsp_valid", 32'(bus.rsp_valid_o), 32'h1);
    chk("lit_mull_rsp_id", 32'(bus.rsp_id_o), 32'h0);
    chk("lit_mull_result", bus.rsp_result_o, 32'd42);
    advance();

    // Next IDLE: req0 re-requests (MULL 5*3) but req1 wins the tie.
    bus.rsp_ready_i = 1'b0;
    set_req(0, 2'd0, 2'd0, 32'd5, 32'd3);
    bus.req_valid_i = 2'b11;
    settle();
    chk("lit_second_tie_ready", 32'(bus.req_ready_o), 32'h2);
    advance();
    bus.req_valid_i = 2'b01;
    bus.md_valid_i = 1'b1;
    bus.md_result_i = unit_calc(2'd2, 32'd100, 32'd7);
    settle();
    chk("lit_div_en", 32'(bus.div_en_o), 32'h1);
    advance();
    bus.md_valid_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      settle();
      chk("lit_hold_rsp_valid", 32'(bus.rsp_valid_o), 32'h1);
      chk("lit_hold_rsp_id", 32'(bus.rsp_id_o), 32'h1);
      chk("lit_hold_result", bus.rsp_result_o, 32'd14);
      chk("lit_hold_no_grant", 32'(bus.req_ready_o), 32'h0);
      advance();
    end
    bus.rsp_ready_i = 1'b1;
    settle();
    advance();
    bus.rsp_ready_i = 1'b0;
    settle();
    chk("lit_idle_after_rsp", 32'(bus.busy_o), 32'h0);
    chk("lit_req0_granted", 32'(bus.req_ready_o), 32'h1);
    advance();

    // Requester changes op_a after acceptance; latched copy must not move.
    bus.req_valid_i = 2'b00;
    set_req(0, 2'd0, 2'd0, 32'd9, 32'd3);
    settle();
    chk("lit_op_a_stable_busy", bus.op_a_o, 32'd5);
    advance();
    bus.md_valid_i = 1'b1;
    bus.md_result_i = unit_calc(2'd0, 32'd5, 32'd3);
    settle();
    advance();
    bus.md_valid_i = 1'b0;
    bus.rsp_ready_i = 1'b1;
    settle();
    chk("lit_op_a_stable_resp", bus.op_a_o, 32'd5);
    chk("lit_result_15", bus.rsp_result_o, 32'd15);
    advance();
    bus.rsp_ready_i = 1'b0;

    // Watchdog: req1 DIV 50/5 with the unit stalled.
    set_req(1, 2'd2, 2'd0, 32'd50, 32'd5);
    bus.req_valid_i = 2'b10;
    settle();
    advance();
    bus.req_valid_i = 2'b00;
    for (int k = 0; k < int'(WDOG); k++) begin
      settle();
      chk("lit_wdog_not_yet", 32'(bus.wdog_err_o), 32'h0);
      advance();
    end
    settle();
    chk("lit_wdog_set", 32'(bus.wdog_err_o), 32'h1);
    chk("lit_wdog_div_en", 32'(bus.div_en_o), 32'h1);
    advance();
    bus.md_valid_i = 1'b1;
    bus.md_result_i = unit_calc(2'd2, 32'd50, 32'd5);
    settle();
    advance();
    bus.md_valid_i = 1'b0;
    bus.rsp_ready_i = 1'b1;
    settle();
    chk("lit_wdog_rsp_valid", 32'(bus.rsp_valid_o), 32'h1);
    chk("lit_wdog_result", bus.rsp_result_o, 32'd10);
    advance();
    bus.rsp_ready_i = 1'b0;

    // Reset in the middle of BUSY.
    set_req(0, 2'd1, 2'd3, 32'd11, 32'd13);
    bus.req_valid_i = 2'b01;
    settle();
    advance();
    bus.req_valid_i = 2'b00;
    settle();
    advance();
    rst_i = 1'b1;
    settle();
    advance();
    rst_i = 1'b0;
    settle();
    chk("lit_rst_busy", 32'(bus.busy_o), 32'h0);
    chk("lit_rst_mult_en", 32'(bus.mult_en_o), 32'h0);
    chk("lit_rst_op_a", bus.op_a_o, 32'h0);
    chk("lit_rst_wdog", 32'(bus.wdog_err_o), 32'h0);
    advance();
    bus.req_valid_i = 2'b11;
    settle();
    chk("lit_rst_tie_req0", 32'(bus.req_ready_o), 32'h1);
    advance();
    bus.req_valid_i = 2'b00;
    bus.md_valid_i = 1'b1;
    bus.md_result_i = unit_calc(m_op, m_a, m_b);
    settle();
    advance();
    bus.md_valid_i = 1'b0;
    bus.rsp_ready_i = 1'b1;
    settle();
    advance();

    // Randomized traffic; requesters hold valid until granted.
    for (int c = 0; c < 3000; c++) begin
      int g;
      rst_i = ($urandom_range(0, 299) == 0);
      for (int r = 0; r < 2; r++) begin
        if (!pend[r] && $urandom_range(0, 2) == 0) begin
          pend[r] = 1;
          set_req(r, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), $urandom(), $urandom());
        end
      end
      bus.req_valid_i = {pend[1], pend[0]};
      bus.md_valid_i  = ($urandom_range(0, 3) == 0);
      bus.md_result_i = m_inflight ? unit_calc(m_op, m_a, m_b) : $urandom();
      bus.rsp_ready_i = 1'($urandom_range(0, 1));
      settle();
      g = m_grant;
      advance();
      if (g >= 0) begin
        pend[g] = 0;
        set_req(g, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), $urandom(), $urandom());
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
